// File: rtl/exe_muldiv_iter.sv
// Iterative RV32M/RV64M multiply/divide unit for the execute stage.
// Multiplies by shift-add and divides by restoring subtraction, retiring
// BITS_PER_CYCLE bits per CALC cycle on operand magnitudes; FIX applies signs.
// Handshake: exe holds start_i-equivalent start_in high with a stable op while
// stall_req_out is high; the result is valid for exactly the one cycle that
// done_out is high, after which the unit is back in IDLE.
module exe_muldiv_iter #(
  parameter int XLEN           = 32,
  parameter int BITS_PER_CYCLE = 1,
  parameter int RADDR_W        = 5
) (
  input  logic               clk_in,
  input  logic               reset_in,
  input  logic               start_in,
  input  logic [2:0]         funct3_in,
  input  logic [XLEN-1:0]    op1_in,
  input  logic [XLEN-1:0]    op2_in,
  input  logic [RADDR_W-1:0] reg_waddr_in,
  input  logic               flush_in,
  output logic               stall_req_out,
  output logic               busy_out,
  output logic               done_out,
  output logic [XLEN-1:0]    reg_wdata_out,
  output logic [RADDR_W-1:0] reg_waddr_out,
  output logic               reg_we_out,
  output logic [1:0]         state_dbg_out
);

  localparam int BPC   = BITS_PER_CYCLE;
  localparam int ITER  = XLEN / BPC;
  localparam int CNT_W = (ITER > 1) ? $clog2(ITER) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(ITER - 1);
  localparam logic [XLEN-1:0]   ONE      = {{(XLEN-1){1'b0}}, 1'b1};
  localparam logic [2*XLEN-1:0] ONE2     = {{(2*XLEN-1){1'b0}}, 1'b1};
  localparam logic [XLEN-1:0]   MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q;
  logic [2:0]          funct3_q;
  logic [XLEN-1:0]     opb_q;     // multiplicand (mul) or divisor (div) magnitude
  logic [2*XLEN-1:0]   acc_q;     // product accumulator; low half is quotient for div
  logic [XLEN:0]       rem_q;     // partial remainder
  logic                neg_q;     // product / quotient sign
  logic                rneg_q;    // remainder sign (dividend sign)
  logic [RADDR_W-1:0]  rd_q;
  logic [XLEN-1:0]     result_q;

  // Operand decode on the issuing op: signedness, magnitudes and fast paths.
  logic            op1_signed, op2_signed, op1_neg, op2_neg, is_div_in;
  logic            op2_zero, div_ovf, fast_hit, launch;
  logic [XLEN-1:0] abs1, abs2, fast_res;

  assign op1_signed = (funct3_in == 3'b001) | (funct3_in == 3'b010) |
                      (funct3_in == 3'b100) | (funct3_in == 3'b110);
  assign op2_signed = (funct3_in == 3'b001) | (funct3_in == 3'b100) |
                      (funct3_in == 3'b110);
  assign op1_neg    = op1_signed & op1_in[XLEN-1];
  assign op2_neg    = op2_signed & op2_in[XLEN-1];
  assign abs1       = op1_neg ? (~op1_in + ONE) : op1_in;
  assign abs2       = op2_neg ? (~op2_in + ONE) : op2_in;
  assign is_div_in  = funct3_in[2];
  assign op2_zero   = (op2_in == '0);
  assign div_ovf    = is_div_in & ~funct3_in[0] & (op1_in == MIN_NEG) & (&op2_in);
  assign fast_hit   = is_div_in & (op2_zero | div_ovf);
  assign fast_res   = op2_zero ? (funct3_in[1] ? op1_in : '1)
                               : (funct3_in[1] ? '0 : op1_in);
  assign launch     = (state_q == S_IDLE) & start_in & ~flush_in;

  // One CALC iteration: BPC bits of shift-add or restoring subtraction.
  logic [XLEN+BPC-1:0] mul_sum, mul_mcand_ext, mul_digit_ext;
  logic [XLEN:0]       div_r, div_diff;
  logic [XLEN-1:0]     div_q;
  always_comb begin
    mul_mcand_ext = {{BPC{1'b0}}, opb_q};
    mul_digit_ext = {{XLEN{1'b0}}, acc_q[BPC-1:0]};
    mul_sum       = {{BPC{1'b0}}, acc_q[2*XLEN-1:XLEN]} + mul_mcand_ext * mul_digit_ext;
    div_r         = rem_q;
    div_q         = acc_q[XLEN-1:0];
    div_diff      = '0;
    for (int i = 0; i < BPC; i++) begin
      div_r    = {div_r[XLEN-1:0], div_q[XLEN-1]};
      div_q    = {div_q[XLEN-2:0], 1'b0};
      div_diff = div_r - {1'b0, opb_q};
      if (!div_diff[XLEN]) begin
        div_r    = div_diff;
        div_q[0] = 1'b1;
      end
    end
  end

  // Sign correction and result selection for the FIX cycle.
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quot, remd, fix_res;
  always_comb begin
    prod = neg_q  ? (~acc_q + ONE2) : acc_q;
    quot = neg_q  ? (~acc_q[XLEN-1:0] + ONE) : acc_q[XLEN-1:0];
    remd = rneg_q ? (~rem_q[XLEN-1:0] + ONE) : rem_q[XLEN-1:0];
    case (funct3_q)
      3'b000:                fix_res = prod[XLEN-1:0];
      3'b001, 3'b010, 3'b011: fix_res = prod[2*XLEN-1:XLEN];
      3'b100, 3'b101:        fix_res = quot;
      default:               fix_res = remd;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic and pipeline-facing outputs; flush overrides everything.
  always_comb begin
    state_d       = state_q;
    stall_req_out = 1'b0;
    done_out      = 1'b0;
    case (state_q)
      S_IDLE: if (launch) begin
        state_d       = fast_hit ? S_DONE : S_CALC;
        stall_req_out = 1'b1;
      end
      S_CALC: begin
        stall_req_out = 1'b1;
        if (cnt_q == CNT_LAST) state_d = S_FIX;
      end
      S_FIX: begin
        stall_req_out = 1'b1;
        state_d       = S_DONE;
      end
      default: begin
        done_out = 1'b1;
        state_d  = S_IDLE;
      end
    endcase
    if (flush_in) begin
      state_d       = S_IDLE;
      stall_req_out = 1'b0;
      done_out      = 1'b0;
    end
  end

  // Datapath: latch the op in IDLE, iterate in CALC, capture the result in FIX.
  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      cnt_q    <= '0;
      funct3_q <= '0;
      opb_q    <= '0;
      acc_q    <= '0;
      rem_q    <= '0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      rd_q     <= '0;
      result_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: if (launch) begin
          cnt_q    <= '0;
          funct3_q <= funct3_in;
          rd_q     <= reg_waddr_in;
          neg_q    <= op1_neg ^ op2_neg;
          rneg_q   <= op1_neg;
          rem_q    <= '0;
          opb_q    <= is_div_in ? abs2 : abs1;
          acc_q    <= {{XLEN{1'b0}}, (is_div_in ? abs1 : abs2)};
          if (fast_hit) result_q <= fast_res;
        end
        S_CALC: begin
          if (cnt_q != CNT_LAST) cnt_q <= cnt_q + 1'b1;
          if (funct3_q[2]) begin
            acc_q <= {acc_q[2*XLEN-1:XLEN], div_q};
            rem_q <= div_r;
          end else begin
            acc_q <= {mul_sum, acc_q[XLEN-1:BPC]};
          end
        end
        S_FIX:   result_q <= fix_res;
        default: ;
      endcase
    end
  end

  assign busy_out      = (state_q != S_IDLE);
  assign reg_wdata_out = result_q;
  assign reg_waddr_out = rd_q;
  assign reg_we_out    = done_out & (rd_q != '0);
  assign state_dbg_out = state_q;

endmodule
